// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and status types for the FWFT block-RAM FIFO
package fifo_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 10;
  localparam int DEPTH = 1 << ADDR_WIDTH_DEFAULT;

  function automatic int cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, almost_full: 1'b0, empty: 1'b1};

endpackage

// File: rtl/bram_fifo_fwft_ctrl_ram.sv
// rtl/bram_fifo_fwft_ctrl_ram.sv - simple dual-port RAM, registered read-first read port
module bram_fifo_fwft_ctrl_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Same-address write and read return the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= din;
    dout <= mem[addr_r];
  end

endmodule

// File: rtl/bram_fifo_fwft_ctrl.sv
// rtl/bram_fifo_fwft_ctrl.sv - first-word-fall-through FIFO controller around a read-first SDP RAM
module bram_fifo_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int CNT_W = cnt_w(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth(ADDR_WIDTH));
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LEVEL);

  typedef struct packed {
    fifo_flags_t      flags;
    logic [CNT_W-1:0] count;
  } status_t;

  localparam status_t STATUS_RST = '{flags: FLAGS_RST, count: '0};

  status_t               status_q, status_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;
  logic                  wr_fire, rd_fire;
  logic [CNT_W-1:0]      popped_cnt;

  assign wr_fire = wr_en & ~status_q.flags.full;
  assign rd_fire = rd_en & ~status_q.flags.empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(wr_fire);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_fire);
    popped_cnt = status_q.count - CNT_W'(rd_fire);
    wr_err_d   = wr_en & status_q.flags.full;
    rd_err_d   = rd_en & status_q.flags.empty;

    status_d                   = status_q;
    status_d.count             = popped_cnt + CNT_W'(wr_fire);
    status_d.flags.full        = (status_d.count == DEPTH_C);
    status_d.flags.almost_full = (status_d.count >= AFULL_C);
    // A word written to the head slot this edge is read stale; hold empty one more cycle.
    status_d.flags.empty       = (status_d.count == '0) || ((popped_cnt == '0) && wr_fire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= STATUS_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      status_q <= status_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Read address tracks the next head so dout always holds memory[rd_ptr].
  bram_fifo_fwft_ctrl_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .addr_w(wr_ptr_q),
    .din   (wr_data),
    .addr_r(rd_ptr_d),
    .dout  (rd_data)
  );

  assign full        = status_q.flags.full;
  assign almost_full = status_q.flags.almost_full;
  assign empty       = status_q.flags.empty;
  assign count       = status_q.count;
  assign wr_err      = wr_err_q;
  assign rd_err      = rd_err_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
    status_q.count <= DEPTH_C);
  a_ptr_order : assert property (@(posedge clk) disable iff (!reset_n)
    (wr_ptr_q - rd_ptr_q) == status_q.count[ADDR_WIDTH-1:0]);

endmodule

// File: tb/tb_bram_fifo_fwft_ctrl.sv
// tb/tb_bram_fifo_fwft_ctrl.sv - directed self-checking bench for the FWFT FIFO controller
module tb_bram_fifo_fwft_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full, almost_full, empty, wr_err, rd_err;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  bram_fifo_fwft_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .almost_full(almost_full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .count      (count),
    .wr_err     (wr_err),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    // reset then idle
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_count", count, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_errs", {wr_err, rd_err}, 0);
    end

    // write-to-empty latency
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    check("w2e_e0_empty", empty, 1);
    check("w2e_e0_count", count, 1);
    step();
    check("w2e_e1_empty", empty, 0);
    check("w2e_e1_data", rd_data, 8'hA5);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("w2e_pop_empty", empty, 1);
    check("w2e_pop_count", count, 0);

    // fill, overflow, drain
    for (int i = 0; i < DEP; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
      check("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_full", full, (i + 1 == DEP) ? 1 : 0);
    end
    check("fill_count", count, DEP);
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    check("ovf_err", wr_err, 1);
    check("ovf_count", count, DEP);
    step();
    check("ovf_err_clr", wr_err, 0);
    for (int i = 0; i < DEP; i++) begin
      check("drain_empty", empty, 0);
      check("drain_data", rd_data, i);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("drain_done_empty", empty, 1);
    check("drain_done_count", count, 0);
    check("drain_full", full, 0);

    // underflow
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("udf_err", rd_err, 1);
    check("udf_count", count, 0);
    step();
    check("udf_err_clr", rd_err, 0);
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    step();
    check("udf_after_data", rd_data, 8'h5A);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("udf_after_empty", empty, 1);

    // streaming across pointer wrap
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    check("strm_pre_count", count, 5);
    for (int j = 0; j < 3 * DEP; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(j + 5);
      check("strm_empty", empty, 0);
      check("strm_data", rd_data, j);
      step();
      check("strm_count", count, 5);
    end
    wr_en = 1'b0;
    for (int j = 3 * DEP; j < 3 * DEP + 5; j++) begin
      rd_en = 1'b1;
      check("strm_tail", rd_data, j);
      step();
    end
    rd_en = 1'b0;
    check("strm_end_empty", empty, 1);

    // reset mid-stream
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h10 + i);
      step();
    end
    check("mid_count", count, 7);
    rd_en = 1'b1; wr_data = 8'hEE;
    reset_n = 1'b0;
    #1;
    check("mid_async_count", count, 0);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    reset_n = 1'b1;
    step();
    check("mid_rel_empty", empty, 1);
    check("mid_rel_count", count, 0);
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    check("mid_push_empty", empty, 0);
    check("mid_push_data", rd_data, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
